ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 101 ++++++++++
 tb/tb_ifetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register plus a four-state fetch FSM.
// The FSM reads one word per request into either ir or imm_out.
module ifetch_unit #(
  parameter int BUS_WIDTH = 16,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_read,
  input  logic                 imm_sel,
  input  logic                 pc_inc,
  input  logic                 jump,
  input  logic                 alu_zero,
  input  logic [ADDR_W-1:0]    jump_addr,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  input  logic                 imem_valid,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic                 imem_rd_en,
  output logic [ADDR_W-1:0]    pc,
  output logic [BUS_WIDTH-1:0] ir,
  output logic [BUS_WIDTH-1:0] imm_out,
  output logic                 busy,
  output logic                 fetch_done,
  output logic                 fetch_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  state_t     next;
  logic [7:0] wcnt;
  logic       dest;
  logic       wait_last;

  assign wait_last = (wcnt == 8'(TIMEOUT - 1));

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (imem_read) next = REQ;
      REQ:  next = WAIT;
      WAIT: begin
        if (imem_valid)     next = DONE;
        else if (wait_last) next = IDLE;
      end
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Status outputs are registered and track the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wcnt       <= '0;
      dest       <= 1'b0;
      imem_addr  <= '0;
      imem_rd_en <= 1'b0;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      ir         <= '0;
      imm_out    <= '0;
    end else begin
      state      <= next;
      imem_rd_en <= (next == REQ);
      busy       <= (next != IDLE);
      fetch_done <= (next == DONE);
      if (state == IDLE && imem_read) begin
        imem_addr <= pc;
        dest      <= imm_sel;
      end
      if (state == REQ)
        wcnt <= '0;
      else if (state == WAIT)
        wcnt <= wcnt + 8'd1;
      if (state == WAIT && imem_valid) begin
        if (dest) imm_out <= imem_rdata;
        else      ir      <= imem_rdata;
      end
      if (state == WAIT && !imem_valid && wait_last)
        fetch_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc <= '0;
    else if (jump && !alu_zero)
      pc <= jump_addr;
    else if (pc_inc || jump)
      pc <= pc + ADDR_W'(1);
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit.
// A responder models the memory; a monitor pops expected fetches.
module tb_ifetch_unit;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_read = 1'b0;
  logic        imm_sel = 1'b0;
  logic        pc_inc = 1'b0;
  logic        jump = 1'b0;
  logic        alu_zero = 1'b0;
  logic [7:0]  jump_addr = 8'd0;
  logic [15:0] imem_rdata = 16'd0;
  logic        imem_valid = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [15:0] imm_out;
  logic        busy;
  logic        fetch_done;
  logic        fetch_err;

  ifetch_unit #(.BUS_WIDTH(16), .ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .imem_read(imem_read),
    .imm_sel(imm_sel), .pc_inc(pc_inc), .jump(jump),
    .alu_zero(alu_zero), .jump_addr(jump_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .pc(pc),
    .ir(ir), .imm_out(imm_out), .busy(busy),
    .fetch_done(fetch_done), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        dest;
    logic [15:0] data;
    int          lat;
    bit          to;
  } txn_t;

  txn_t        q[$];
  logic [15:0] mem[256];
  int          n_tests = 0;
  int          n_fail = 0;
  int          pops = 0;
  int          rd_cnt = 0;
  int          issued = 0;
  int          cur_lat = 1;
  logic [7:0]  mpc = 8'd0;
  bit          issuing = 0;
  logic [15:0] want_ir = 16'd0;
  logic [15:0] want_imm = 16'd0;
  logic        want_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // One clock: record accepted request, advance PC model, return at negedge
  task automatic tick();
    @(posedge clk);
    if (issuing && imem_read && !reset) begin
      q.push_back('{mpc, imm_sel, mem[mpc], cur_lat,
                    (cur_lat == 0 || cur_lat > TO)});
      issued++;
    end
    if (reset)                  mpc = 8'd0;
    else if (jump && !alu_zero) mpc = jump_addr;
    else if (pc_inc || jump)    mpc = mpc + 8'd1;
    @(negedge clk);
  endtask

  task automatic rand_pc();
    pc_inc    = 1'($urandom_range(0, 1));
    jump      = ($urandom_range(0, 7) == 0);
    alu_zero  = 1'($urandom_range(0, 1));
    jump_addr = 8'($urandom);
  endtask

  task automatic set_pc(input logic [7:0] a);
    jump = 1'b1; alu_zero = 1'b0; pc_inc = 1'b0; jump_addr = a;
    tick();
    jump = 1'b0;
  endtask

  task automatic fetch(input bit dest, input int lat, input bit noise);
    int p0;
    p0 = pops;
    cur_lat = lat;
    imm_sel = dest;
    imem_read = 1'b1;
    issuing = 1;
    if (noise) rand_pc();
    else begin pc_inc = 1'b0; jump = 1'b0; end
    tick();
    issuing = 0;
    imem_read = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (pops != p0) break;
      if (noise) begin
        rand_pc();
        imem_read = ($urandom_range(0, 2) == 0);
      end
      tick();
    end
    imem_read = 1'b0;
    if (pops == p0) fail("fetch_hang");
    if (lat != 0 && lat <= TO) begin
      if (noise) imem_read = 1'($urandom_range(0, 1));
      tick();
      imem_read = 1'b0;
    end else begin
      repeat (6) tick();
    end
    pc_inc = 1'b0;
    jump = 1'b0;
  endtask

  // Memory responder: valid arrives lat cycles after the rd_en cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (imem_rd_en && !reset) begin
        int l;
        logic [7:0] a;
        l = cur_lat;
        a = imem_addr;
        if (l != 0) begin
          repeat (l + 1) @(negedge clk);
          imem_valid = 1'b1;
          imem_rdata = mem[a];
          @(negedge clk);
          imem_valid = 1'b0;
          imem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Monitor
  initial begin
    int   bcnt;
    logic pb, pd, pr;
    txn_t t;
    bcnt = 0; pb = 0; pd = 0; pr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        q.delete();
        want_ir = 16'd0; want_imm = 16'd0; want_err = 1'b0;
        bcnt = 0; pb = 0; pd = 0; pr = 0;
        check("rst_busy", busy, 0);
        check("rst_done", fetch_done, 0);
        check("rst_rd_en", imem_rd_en, 0);
        check("rst_ir", ir, 0);
        check("rst_imm", imm_out, 0);
        check("rst_err", fetch_err, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_pc", pc, 0);
      end else begin
        if (imem_rd_en) begin
          rd_cnt++;
          check("rd_en_pulse_prev", pr, 0);
          if (q.size() == 0) fail("rd_en_unexpected");
          else check("imem_addr", imem_addr, q[0].addr);
        end
        if (busy) bcnt++;
        if (fetch_done) begin
          check("done_pulse_prev", pd, 0);
          if (q.size() == 0) fail("spurious_done");
          else begin
            t = q.pop_front();
            pops++;
            check("done_not_timeout", t.to, 0);
            check("busy_cycles", bcnt, t.lat + 2);
            if (t.dest) want_imm = t.data;
            else        want_ir  = t.data;
          end
        end else if (!busy && pb && !pd) begin
          if (q.size() == 0) fail("spurious_busy_end");
          else begin
            t = q.pop_front();
            pops++;
            check("timeout_expected", t.to, 1);
            check("timeout_busy_cycles", bcnt, TO + 1);
            want_err = 1'b1;
          end
        end
        if (!busy) bcnt = 0;
        check("ir", ir, want_ir);
        check("imm_out", imm_out, want_imm);
        check("fetch_err", fetch_err, want_err);
        check("pc", pc, mpc);
        pb = busy; pd = fetch_done; pr = imem_rd_en;
      end
    end
  end

  initial begin
    int r;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h2345;
    mem[5] = 16'h00A7;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    fetch(0, 1, 0);
    check("d035_ir", ir, 16'h2345);
    check("d035_imm", imm_out, 16'h0000);
    check("d035_addr", imem_addr, 8'h00);

    set_pc(8'd5);
    fetch(1, 4, 0);
    check("d036_imm", imm_out, 16'h00A7);
    check("d036_ir", ir, 16'h2345);

    set_pc(8'd9);
    jump = 1'b1; alu_zero = 1'b0; jump_addr = 8'h03; pc_inc = 1'b1;
    tick();
    check("d037_taken", pc, 8'h03);
    set_pc(8'd9);
    jump = 1'b1; alu_zero = 1'b1; jump_addr = 8'h03; pc_inc = 1'b1;
    tick();
    check("d037_not_taken", pc, 8'h0A);
    set_pc(8'hFF);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("d038_wrap", pc, 8'h00);

    fetch(0, 0, 0);
    check("d039_err", fetch_err, 1);
    check("d039_ir", ir, 16'h2345);
    set_pc(8'd5);
    fetch(0, 2, 0);
    check("d039_ir_after", ir, 16'h00A7);
    check("d039_err_sticky", fetch_err, 1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      fetch(1'($urandom), 0, 1);
      else if (r == 1) fetch(1'($urandom), 20, 1);
      else             fetch(1'($urandom), $urandom_range(1, 6), 1);
    end

    cur_lat = 2;
    imm_sel = 1'b0;
    pc_inc = 1'b0; jump = 1'b0;
    imem_read = 1'b1;
    issuing = 1;
    tick();
    issuing = 0;
    imem_read = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("d040_busy", busy, 0);
    check("d040_ir", ir, 0);
    repeat (6) tick();
    check("d040_ir_late", ir, 0);
    check("d040_idle", busy, 0);

    check("rd_en_count", rd_cnt, issued);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
